// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage with result select, load formatting, register file,
// same-cycle operand bypass and a per-register pending-write scoreboard.
module wb_regfile #(
  parameter  int unsigned XLEN         = 32,
  parameter  int unsigned NUM_REGS     = 32,
  parameter  int unsigned NUM_RD_PORTS = 2,
  localparam int unsigned AW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_valid,
  input  logic                         wb_we,
  input  logic [AW-1:0]                wb_rd,
  input  logic [1:0]                   wb_sel,
  input  logic [1:0]                   wb_mem_size,
  input  logic                         wb_mem_unsigned,
  input  logic [1:0]                   wb_byte_off,
  input  logic [XLEN-1:0]              wb_alu_result,
  input  logic [XLEN-1:0]              wb_mem_data,
  input  logic [XLEN-1:0]              wb_pc,
  input  logic [XLEN-1:0]              wb_imm,
  input  logic                         issue_valid,
  input  logic [AW-1:0]                issue_rd,
  input  logic [NUM_RD_PORTS*AW-1:0]   rd_addr,
  output logic [NUM_RD_PORTS*XLEN-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]      rd_busy,
  output logic                         commit_valid,
  output logic [AW-1:0]                commit_rd,
  output logic [XLEN-1:0]              commit_data
);

  typedef enum logic [1:0] {
    SEL_ALU = 2'b00,
    SEL_MEM = 2'b01,
    SEL_PC4 = 2'b10,
    SEL_IMM = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_WRD2 = 2'b11
  } mem_size_e;

  // Indices at or above NUM_REGS only exist when NUM_REGS is not a power of 2.
  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic            s_v_q, s_v_d;
  logic [AW-1:0]   s_rd_q, s_rd_d;
  logic [XLEN-1:0] s_data_q, s_data_d;

  logic [31:0]     lane;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic            sext;
  logic [XLEN-1:0] mem_fmt;
  logic [XLEN-1:0] result;

  // Load lane extraction and extension, then result source select.
  always_comb begin
    lane   = wb_mem_data[31:0];
    sext   = ~wb_mem_unsigned;
    lane_h = wb_byte_off[1] ? lane[31:16] : lane[15:0];
    case (wb_byte_off)
      2'd0:    lane_b = lane[7:0];
      2'd1:    lane_b = lane[15:8];
      2'd2:    lane_b = lane[23:16];
      default: lane_b = lane[31:24];
    endcase
    // Fill with the extension bit first, then overlay the lane, so no
    // zero-width replication is needed when XLEN equals 32.
    case (mem_size_e'(wb_mem_size))
      SZ_BYTE: begin
        mem_fmt      = {XLEN{sext & lane_b[7]}};
        mem_fmt[7:0] = lane_b;
      end
      SZ_HALF: begin
        mem_fmt       = {XLEN{sext & lane_h[15]}};
        mem_fmt[15:0] = lane_h;
      end
      default: begin
        mem_fmt       = {XLEN{sext & lane[31]}};
        mem_fmt[31:0] = lane;
      end
    endcase
    case (wb_sel_e'(wb_sel))
      SEL_ALU: result = wb_alu_result;
      SEL_MEM: result = mem_fmt;
      SEL_PC4: result = wb_pc + XLEN'(4);
      default: result = wb_imm;
    endcase
  end

  // Stage register next state; x0 destinations never become a commit.
  always_comb begin
    s_v_d    = wb_valid & wb_we & (wb_rd != '0);
    s_rd_d   = wb_rd;
    s_data_d = result;
  end

  // Register file next state: commit the staged result, x0 stays zero.
  always_comb begin
    regs_d = regs_q;
    if (s_v_q && (s_rd_q != '0) && in_range(s_rd_q)) begin
      regs_d[s_rd_q] = s_data_q;
    end
    regs_d[0] = '0;
  end

  // Scoreboard next state: clear on commit, then a new issue overrides the clear.
  always_comb begin
    busy_d = busy_q;
    if (s_v_q && in_range(s_rd_q)) begin
      busy_d[s_rd_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0) && in_range(issue_rd)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State update with synchronous reset taking priority over all traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_v_q    <= 1'b0;
      s_rd_q   <= '0;
      s_data_q <= '0;
      busy_q   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      s_v_q    <= s_v_d;
      s_rd_q   <= s_rd_d;
      s_data_q <= s_data_d;
      busy_q   <= busy_d;
      regs_q   <= regs_d;
    end
  end

  assign commit_valid = s_v_q;
  assign commit_rd    = s_rd_q;
  assign commit_data  = s_data_q;

  logic [AW-1:0] rd_a;
  logic          hit;

  // Operand reads: bypass the value committing this cycle, mask its busy bit.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_a    = '0;
    hit     = 1'b0;
    for (int unsigned k = 0; k < NUM_RD_PORTS; k++) begin
      rd_a = rd_addr[k*AW +: AW];
      hit  = s_v_q && (s_rd_q == rd_a);
      if ((rd_a != '0) && in_range(rd_a)) begin
        rd_data[k*XLEN +: XLEN] = hit ? s_data_q : regs_q[rd_a];
        rd_busy[k]              = busy_q[rd_a] & ~hit;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// checked against a behavioural model of the write-back stage.
module tb_wb_regfile;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NR   = 32;
  localparam int unsigned NP   = 2;
  localparam int unsigned AW   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_valid, wb_we, wb_mem_unsigned;
  logic [AW-1:0]    wb_rd;
  logic [1:0]       wb_sel, wb_mem_size, wb_byte_off;
  logic [XLEN-1:0]  wb_alu_result, wb_mem_data, wb_pc, wb_imm;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*XLEN-1:0] rd_data;
  logic [NP-1:0]    rd_busy;
  logic             commit_valid;
  logic [AW-1:0]    commit_rd;
  logic [XLEN-1:0]  commit_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [31:0]   m_regs [NR];
  logic          m_busy [NR];
  logic          m_sv;
  logic [AW-1:0] m_srd;
  logic [31:0]   m_sdata;

  // Load formatting cases on 0x80FF7F01
  logic [1:0]  lf_size [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd3};
  logic        lf_uns  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0]  lf_off  [7] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3, 2'd1};
  logic [31:0] lf_exp  [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                               32'h0000007F, 32'h000080FF, 32'h80FF7F01};

  wb_regfile #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD_PORTS(NP)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_sel(wb_sel),
    .wb_mem_size(wb_mem_size), .wb_mem_unsigned(wb_mem_unsigned), .wb_byte_off(wb_byte_off),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_pc(wb_pc), .wb_imm(wb_imm),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data)
  );

  always #5 clk = ~clk;

  // Result value from the source-select and load rules, in plain arithmetic.
  function automatic logic [31:0] model_result();
    logic [31:0] v;
    case (wb_sel)
      2'd0: v = wb_alu_result;
      2'd2: v = wb_pc + 32'd4;
      2'd3: v = wb_imm;
      default: begin
        if (wb_mem_size == 2'd0) begin
          v = (wb_mem_data >> (8 * wb_byte_off)) & 32'hFF;
          if (!wb_mem_unsigned && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (wb_mem_size == 2'd1) begin
          v = (wb_mem_data >> (16 * wb_byte_off[1])) & 32'hFFFF;
          if (!wb_mem_unsigned && v >= 32'd32768) v = v + 32'hFFFF0000;
        end else begin
          v = wb_mem_data;
        end
      end
    endcase
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return 32'd0;
    if (m_sv && m_srd == a) return m_sdata;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !(m_sv && m_srd == a);
  endfunction

  // Advance the model by one edge using the currently driven inputs, then the clock.
  task automatic tick();
    logic [31:0] res;
    res = model_result();
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
      m_sv = 1'b0; m_srd = '0; m_sdata = 32'd0;
    end else begin
      if (m_sv) begin
        m_regs[m_srd] = m_sdata;
        m_busy[m_srd] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      m_sv    = wb_valid && wb_we && (wb_rd != 0);
      m_srd   = wb_rd;
      m_sdata = res;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_we = 1'b0; issue_valid = 1'b0;
  endtask

  task automatic drive_write(input logic [AW-1:0] rd, input logic [1:0] sel, input logic [31:0] val);
    wb_valid = 1'b1; wb_we = 1'b1; wb_rd = rd; wb_sel = sel;
    wb_alu_result = val; wb_imm = val; wb_pc = val; wb_mem_data = val;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_commit_valid: got %b expected 0", commit_valid);
    end
    for (int a = 0; a < NR; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      #1;
      n_tests++;
      if (rd_data !== '0 || rd_busy !== '0) begin
        n_fail++; $display("FAIL reset_regs x%0d: got data %h busy %b expected 0", a, rd_data, rd_busy);
      end
      tick();
    end
    // Mid-traffic reset: pending commit to x9 and busy x10, then reset with new traffic.
    drive_write(5'd9, 2'd0, 32'hA5A5A5A5);
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    drive_write(5'd11, 2'd0, 32'h5A5A5A5A);
    issue_valid = 1'b1; issue_rd = 5'd12;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; idle();
    rd_addr = {5'd10, 5'd9};
    #1;
    n_tests++;
    if (commit_valid !== 1'b0 || commit_data !== 32'd0 || commit_rd !== 5'd0) begin
      n_fail++; $display("FAIL reset_mid_commit: got v=%b rd=%0d d=%h expected all 0", commit_valid, commit_rd, commit_data);
    end
    tick();
    for (int p = 0; p < 2; p++) begin
      rd_addr = (p == 0) ? {5'd10, 5'd9} : {5'd12, 5'd11};
      #1;
      n_tests++;
      if (rd_data !== '0 || rd_busy !== '0) begin
        n_fail++; $display("FAIL reset_mid_state pair%0d: got data %h busy %b expected 0", p, rd_data, rd_busy);
      end
      tick();
    end
  endtask

  task automatic test_src_select();
    rd_addr = {5'd0, 5'd5};
    drive_write(5'd5, 2'd0, 32'hDEADBEEF);
    tick(); idle(); #1;
    n_tests++;
    if (commit_valid !== 1'b1 || commit_rd !== 5'd5 || commit_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL alu_commit: got v=%b rd=%0d d=%h expected 1/5/deadbeef", commit_valid, commit_rd, commit_data);
    end
    n_tests++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL alu_bypass: got %h expected deadbeef", rd_data[31:0]);
    end
    tick(); #1;
    n_tests++;
    if (rd_data[31:0] !== 32'hDEADBEEF || commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL alu_regread: got %h v=%b expected deadbeef v=0", rd_data[31:0], commit_valid);
    end
    // PC+4 wrap overwriting a non-zero value
    rd_addr = {5'd0, 5'd6};
    drive_write(5'd6, 2'd0, 32'h00000055);
    tick();
    drive_write(5'd6, 2'd2, 32'hFFFFFFFC);
    tick(); idle(); #1;
    n_tests++;
    if (commit_valid !== 1'b1 || commit_data !== 32'h00000000) begin
      n_fail++; $display("FAIL pc4_wrap: got v=%b d=%h expected 1/00000000", commit_valid, commit_data);
    end
    tick(); #1;
    n_tests++;
    if (rd_data[31:0] !== 32'h00000000) begin
      n_fail++; $display("FAIL pc4_regread: got %h expected 00000000", rd_data[31:0]);
    end
    drive_write(5'd6, 2'd3, 32'h0BADF00D);
    wb_alu_result = 32'h0;
    tick(); idle(); #1;
    n_tests++;
    if (commit_data !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL imm_commit: got %h expected 0badf00d", commit_data);
    end
    tick();
  endtask

  task automatic test_load_fmt();
    for (int i = 0; i < 7; i++) begin
      drive_write(5'd8, 2'd1, 32'h80FF7F01);
      wb_alu_result = 32'h0;
      wb_mem_size = lf_size[i]; wb_mem_unsigned = lf_uns[i]; wb_byte_off = lf_off[i];
      tick(); idle(); #1;
      n_tests++;
      if (commit_data !== lf_exp[i] || commit_valid !== 1'b1) begin
        n_fail++; $display("FAIL load_fmt case%0d: got %h expected %h", i, commit_data, lf_exp[i]);
      end
    end
    tick();
  endtask

  task automatic test_x0();
    rd_addr = {5'd0, 5'd0};
    drive_write(5'd0, 2'd0, 32'h00001234);
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick(); idle(); #1;
    n_tests++;
    if (commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL x0_commit: got %b expected 0", commit_valid);
    end
    tick(); #1;
    n_tests++;
    if (rd_data !== '0 || rd_busy !== '0) begin
      n_fail++; $display("FAIL x0_read: got data %h busy %b expected 0", rd_data, rd_busy);
    end
  endtask

  task automatic test_scoreboard();
    rd_addr = {5'd7, 5'd7};
    idle(); issue_valid = 1'b1; issue_rd = 5'd7;
    tick(); idle(); #1;
    n_tests++;
    if (rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL sb_issue: got %b expected 11", rd_busy);
    end
    drive_write(5'd7, 2'd0, 32'h77);
    tick(); idle(); #1;
    n_tests++;
    if (rd_busy !== 2'b00 || commit_valid !== 1'b1) begin
      n_fail++; $display("FAIL sb_commit_cycle: got busy %b v=%b expected 00/1", rd_busy, commit_valid);
    end
    tick(); #1;
    n_tests++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL sb_after_commit: got %b expected 00", rd_busy);
    end
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    drive_write(5'd7, 2'd0, 32'h78);
    tick(); idle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    n_tests++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL sb_masked: got %b expected 00", rd_busy);
    end
    tick(); idle(); #1;
    n_tests++;
    if (rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL sb_set_wins: got %b expected 11", rd_busy);
    end
    drive_write(5'd7, 2'd0, 32'h79);
    tick(); idle(); tick(); #1;
    n_tests++;
    if (rd_busy !== 2'b00 || rd_data !== {32'h79, 32'h79}) begin
      n_fail++; $display("FAIL sb_cleanup: got busy %b data %h expected 00 / 79,79", rd_busy, rd_data);
    end
  endtask

  task automatic test_back_to_back();
    rd_addr = {5'd3, 5'd3};
    drive_write(5'd3, 2'd0, 32'h11);
    tick();
    drive_write(5'd3, 2'd0, 32'h22);
    #1;
    n_tests++;
    if (rd_data !== {32'h11, 32'h11}) begin
      n_fail++; $display("FAIL b2b_n1: got %h expected 11,11", rd_data);
    end
    tick(); idle(); #1;
    n_tests++;
    if (rd_data !== {32'h22, 32'h22}) begin
      n_fail++; $display("FAIL b2b_n2: got %h expected 22,22", rd_data);
    end
    tick(); #1;
    n_tests++;
    if (rd_data !== {32'h22, 32'h22}) begin
      n_fail++; $display("FAIL b2b_n3: got %h expected 22,22", rd_data);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a0, a1, ad;
    for (int c = 0; c < 400; c++) begin
      rst             = ($urandom_range(0, 59) == 0);
      wb_valid        = ($urandom_range(0, 3) != 0);
      wb_we           = ($urandom_range(0, 4) != 0);
      wb_rd           = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) wb_rd = 5'($urandom);
      wb_sel          = 2'($urandom);
      wb_mem_size     = 2'($urandom);
      wb_mem_unsigned = 1'($urandom);
      wb_byte_off     = 2'($urandom);
      wb_alu_result   = $urandom;
      wb_mem_data     = $urandom;
      wb_pc           = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      wb_imm          = $urandom;
      issue_valid     = ($urandom_range(0, 2) == 0);
      issue_rd        = 5'($urandom_range(0, 7));
      a0 = 5'($urandom_range(0, 8));
      a1 = 5'($urandom);
      if ($urandom_range(0, 2) == 0) a0 = m_srd;
      if ($urandom_range(0, 3) == 0) a1 = m_srd;
      rd_addr = {a1, a0};
      #1;
      n_tests++;
      if (commit_valid !== m_sv || commit_rd !== m_srd || commit_data !== m_sdata) begin
        n_fail++;
        $display("FAIL rand_commit cyc%0d: got %b/%0d/%h expected %b/%0d/%h",
                 c, commit_valid, commit_rd, commit_data, m_sv, m_srd, m_sdata);
      end
      for (int k = 0; k < NP; k++) begin
        ad = rd_addr[k*AW +: AW];
        n_tests++;
        if (rd_data[k*XLEN +: XLEN] !== exp_rd(ad) || rd_busy[k] !== exp_busy(ad)) begin
          n_fail++;
          $display("FAIL rand_read cyc%0d port%0d x%0d: got %h busy %b expected %h busy %b",
                   c, k, ad, rd_data[k*XLEN +: XLEN], rd_busy[k], exp_rd(ad), exp_busy(ad));
        end
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    wb_valid = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_sel = '0;
    wb_mem_size = '0; wb_mem_unsigned = 1'b0; wb_byte_off = '0;
    wb_alu_result = '0; wb_mem_data = '0; wb_pc = '0; wb_imm = '0;
    issue_valid = 1'b0; issue_rd = '0; rd_addr = '0;
    m_sv = 1'b0; m_srd = '0; m_sdata = '0;
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
    #2;
    test_reset();
    test_src_select();
    test_load_fmt();
    test_x0();
    test_scoreboard();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Parametrised write-back stage with integrated register file, bypass and pending-write scoreboard. It sits at the end of the pipeline and accepts one retiring instruction per cycle. It selects the result source, formats sub-word loads, and commits the result into an `NUM_REGS` x `XLEN` register file. It serves combinational operand reads to decode with same-cycle bypass and busy flags for hazard detection.

## Interface
- `XLEN`, 32: datapath width; must be at least 32.
- `NUM_REGS`, 32: register count; AW = $clog2(NUM_REGS).
- `NUM_RD_PORTS`, 2: operand read ports.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wb_valid` in 1: retiring instruction present this cycle.
- `wb_we` in 1: instruction writes `wb_rd`.
- `wb_rd` in AW: destination register.
- `wb_sel` in 2: result source; 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
- `wb_mem_size` in 2: load size; 00 byte, 01 half, 10 word, 11 treated as word.
- `wb_mem_unsigned` in 1: zero-extend when 1, sign-extend when 0.
- `wb_byte_off` in 2: load address bits [1:0].
- `wb_alu_result`, `wb_mem_data`, `wb_pc`, `wb_imm` in XLEN each: source operands.
- `issue_valid` in 1: an instruction writing `issue_rd` has been issued.
- `issue_rd` in AW: destination of the issued instruction.
- `rd_addr` in NUM_RD_PORTS*AW: read addresses; port k uses slice k.
- `rd_data` out NUM_RD_PORTS*XLEN: read data, combinational.
- `rd_busy` out NUM_RD_PORTS: read register has an outstanding write.
- `commit_valid` out 1: a register write happens at the end of this cycle.
- `commit_rd` out AW: register being written.
- `commit_data` out XLEN: value being written.

## Operation
- **Stage register.** Every edge captures `wb_valid & wb_we & (wb_rd != 0)` as S.v, plus `wb_rd` and the formatted result.
  - `commit_*` are driven directly from the stage register.
  - At the next edge, if S.v = 1, `regs[S.rd] <= S.data`.
- **Source select.**
  - ALU and IMM sources pass through unchanged.
  - PC+4 = `wb_pc + 4`, modulo 2^XLEN.
  - MEM applies the load formatting below.
- **Load formatting.** The lane is taken from `wb_mem_data[31:0]`.
  - byte = bits [8*off+7 : 8*off].
  - half = bits [16*off[1]+15 : 16*off[1]]; off[0] is ignored.
  - word = bits [31:0].
  - The result is then extended to XLEN: sign-extended when `wb_mem_unsigned` = 0, zero-extended when it is 1.
- **Register x0.** `regs[0]` is hardwired to 0.
  - Never written, never marked busy, always reads 0.
  - Writes addressed to x0 never set `commit_valid`.
- **Reads.** For each port: if S.v and `rd_addr[k] == S.rd` and the address is not 0, `rd_data[k] = S.data` (bypass). Otherwise `rd_data[k] = regs[rd_addr[k]]`.
- **Scoreboard.** One busy bit per register.
  - Set at the edge when `issue_valid` = 1 and `issue_rd` != 0.
  - Cleared at the edge when S.v = 1 for that register.
  - Set and clear of the same register in the same cycle: set wins, because a new producer has been issued.
  - `rd_busy[k] = busy[rd_addr[k]] & ~(S.v & S.rd == rd_addr[k])`, i.e. the value being committed this cycle counts as available through the bypass.
- **Retire without write.** `wb_valid` = 0 or `wb_we` = 0 creates no commit and changes no busy bit.
- **Index range.** Indices >= NUM_REGS (possible when NUM_REGS is not a power of 2): writes are dropped, reads return 0, busy reads as 0.

## Timing
- Reset (synchronous) clears all registers to 0, all busy bits to 0, and S.v to 0.
- `commit_valid`, `commit_rd` and `commit_data` read 0 from the first edge with `rst` = 1.
- Inputs arriving during reset are discarded.
- Reset wins over a simultaneous `issue_valid` or `wb_valid`.
- Write latency, with wb inputs at cycle N:
  - `commit_*` are visible in cycle N+1.
  - `rd_data` shows the new value from cycle N+1 via the bypass, and from regs from N+2.
- Back-to-back writes to the same register in N and N+1: reads in N+2 return the N+1 value.
- `rd_data` and `rd_busy` are purely combinational in `rd_addr` and state, with no input-to-output path from `wb_*`.
- Throughput is one commit per cycle with no stall.

## Test plan
- **Reset.** Hold `rst` 2 cycles mid-traffic, with a busy bit set and S.v = 1. Required afterwards: all reads 0, `rd_busy` 0, `commit_valid` 0, and the pending write is not performed.
- **Source select.**
  - ALU 0xDEADBEEF to x5: `commit_data` 0xDEADBEEF in N+1, and port 0 reading x5 returns 0xDEADBEEF in N+1 (bypass) and N+2.
  - PC+4 with `wb_pc` = 0xFFFFFFFC writes 0x00000000.
- **Load formatting.** `wb_mem_data` 0x80FF7F01:
  - signed byte, off 3 -> 0xFFFFFF80;
  - unsigned byte, off 3 -> 0x00000080;
  - signed half, off 2 -> 0xFFFF80FF;
  - unsigned half, off 0 -> 0x00007F01.
- **x0.** Write 0x1234 to x0 with `issue_valid` for x0. Required: `commit_valid` 0, reads of x0 return 0, `rd_busy` 0.
- **Scoreboard.**
  - Issue x7: `rd_busy` = 1 from the next cycle.
  - Commit x7: `rd_busy` = 0 in the commit cycle.
  - Issue x7 and commit x7 in the same cycle: busy remains 1 afterwards.
- **Dual port, back to back.** Writes to x3 in N (0x11) and N+1 (0x22), with ports 0 and 1 both reading x3. Required: 0x11 in N+1, 0x22 in N+2 and N+3.
